dma_stream_writer: RTL and testbench

- DMA responder serving the SoC's dma_request/dma_ack handshake, i.e. the memory-side end of the peripheral DMA path.
- On request it grants, packs the peripheral byte stream into 32-bit words, and writes them to memory at incrementing word addresses.
- It signals completion with a second dma_ack pulse.
- Sits between the peripheral byte port and the memory write port.

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_stream_writer_byte_packer.sv | 45 ++++
 rtl/dma_stream_writer.sv | 129 ++++++++++++
 tb/tb_dma_stream_writer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA stream writer: FSM state encoding and
// word-packing constants.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        PACK,
        WRITE,
        DONE,
        RELEASE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_ADDR_STEP = 4;

endpackage

// File: rtl/dma_stream_writer_byte_packer.sv
// Collects accepted bytes little-endian into a 32-bit word; flags the cycle
// in which the final byte of a word is accepted.
module byte_packer
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (accept_i) begin
            word_d[8*idx_q +: 8] = byte_i;
            idx_d                = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    assign last_o = accept_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/dma_stream_writer.sv
// DMA responder: grants a request, packs peripheral bytes into words and
// writes them to memory at incrementing word addresses.
module dma_stream_writer
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_request,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [CNT_W-1:0]  transfer_words,
    output logic              dma_ack,
    output logic              busy,
    output logic              abort,
    input  logic              peripheral_valid,
    input  logic [7:0]        peripheral_data_in,
    output logic              peripheral_ready,
    output logic [ADDR_W-1:0] memory_address,
    output logic [31:0]       memory_data_out,
    output logic              memory_write_enable,
    input  logic              memory_ready,
    output state_e            state_o
);

    // Handshakes: a byte moves on a rising edge where peripheral_valid and
    // peripheral_ready are both high; a write completes on a rising edge where
    // memory_write_enable and memory_ready are both high. Neither ready/enable
    // ever depends combinationally on the partner's valid/ready.

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic              byte_accept;
    logic              word_last;
    logic              packer_clear;

    assign byte_accept = peripheral_valid && peripheral_ready;

    byte_packer u_packer (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (packer_clear),
        .accept_i (byte_accept),
        .byte_i   (peripheral_data_in),
        .word_o   (memory_data_out),
        .last_o   (word_last)
    );

    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        words_left_d        = words_left_q;
        dma_ack             = 1'b0;
        busy                = (state_q != IDLE);
        abort               = 1'b0;
        peripheral_ready    = 1'b0;
        memory_write_enable = 1'b0;
        packer_clear        = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_request) begin
                    addr_d       = {start_address[ADDR_W-1:2], 2'b00};
                    words_left_d = transfer_words;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                dma_ack = 1'b1;
                state_d = (words_left_q == '0) ? DONE : PACK;
            end
            PACK: begin
                // A dropped request throws away any bytes of the partial word.
                if (!dma_request) begin
                    abort        = 1'b1;
                    packer_clear = 1'b1;
                    state_d      = IDLE;
                end else begin
                    peripheral_ready = 1'b1;
                    if (word_last) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                memory_write_enable = 1'b1;
                if (memory_ready) begin
                    addr_d       = addr_q + ADDR_W'(WORD_ADDR_STEP);
                    words_left_d = words_left_q - 1'b1;
                    if (!dma_request) begin
                        abort   = 1'b1;
                        state_d = IDLE;
                    end else if (words_left_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = PACK;
                    end
                end
            end
            DONE: begin
                dma_ack = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!dma_request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
        end
    end

    assign memory_address = addr_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_dma_stream_writer.sv
// Directed bench for dma_stream_writer: expected ack/abort/write events are
// queued by the stimulus and matched in order by an independent monitor.
module tb_dma_stream_writer;
    import dma_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [1:0] EV_ACK   = 2'd1;
    localparam logic [1:0] EV_ABORT = 2'd2;
    localparam logic [1:0] EV_WRITE = 2'd3;

    logic              clk;
    logic              reset;
    logic              dma_request;
    logic [ADDR_W-1:0] start_address;
    logic [CNT_W-1:0]  transfer_words;
    logic              dma_ack;
    logic              busy;
    logic              abort;
    logic              peripheral_valid;
    logic [7:0]        peripheral_data_in;
    logic              peripheral_ready;
    logic [ADDR_W-1:0] memory_address;
    logic [31:0]       memory_data_out;
    logic              memory_write_enable;
    logic              memory_ready;
    state_e            state_dbg;

    dma_stream_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .dma_request         (dma_request),
        .start_address       (start_address),
        .transfer_words      (transfer_words),
        .dma_ack             (dma_ack),
        .busy                (busy),
        .abort               (abort),
        .peripheral_valid    (peripheral_valid),
        .peripheral_data_in  (peripheral_data_in),
        .peripheral_ready    (peripheral_ready),
        .memory_address      (memory_address),
        .memory_data_out     (memory_data_out),
        .memory_write_enable (memory_write_enable),
        .memory_ready        (memory_ready),
        .state_o             (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          checks        = 0;
    int          failures      = 0;
    int          cyc           = 0;
    int          write_count   = 0;
    int          pready_cycles = 0;
    int          ack_cyc_last  = -1;
    int          ack_cyc_prev  = -1;
    int          mem_mode      = 0;  // 0 always ready, 1 stall 2 cycles, 2 never ready
    int          stall_cnt     = 0;
    logic [65:0] exp_q[$];
    logic        prev_pending  = 1'b0;
    logic [31:0] prev_addr     = '0;
    logic [31:0] prev_data     = '0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
        logic [65:0] act;
        act = {kind, a, d};
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=0x%0h required=none", act);
        end else begin
            check("event", {6'd0, act}, {6'd0, exp_q.pop_front()});
        end
    endtask

    task automatic exp_ack();
        exp_q.push_back({EV_ACK, 32'd0, 32'd0});
    endtask

    task automatic exp_abort();
        exp_q.push_back({EV_ABORT, 32'd0, 32'd0});
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({EV_WRITE, a, d});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("stall_hold", {39'd0, memory_write_enable, memory_address, memory_data_out},
                      {39'd0, 1'b1, prev_addr, prev_data});
            end
            if (peripheral_ready) pready_cycles++;
            if (memory_write_enable && memory_ready) begin
                write_count++;
                observe(EV_WRITE, memory_address, memory_data_out);
            end
            if (dma_ack) begin
                ack_cyc_prev = ack_cyc_last;
                ack_cyc_last = cyc;
                observe(EV_ACK, 32'd0, 32'd0);
            end
            if (abort) observe(EV_ABORT, 32'd0, 32'd0);
            prev_pending = memory_write_enable && !memory_ready;
            prev_addr    = memory_address;
            prev_data    = memory_data_out;
        end
    end

    // ---------------- memory responder ----------------
    always @(posedge clk) begin
        #2;
        case (mem_mode)
            0: memory_ready = 1'b1;
            1: begin
                if (memory_write_enable) begin
                    if (stall_cnt == 2) begin
                        memory_ready = 1'b1;
                        stall_cnt    = 0;
                    end else begin
                        memory_ready = 1'b0;
                        stall_cnt++;
                    end
                end else begin
                    memory_ready = 1'b0;
                    stall_cnt    = 0;
                end
            end
            default: memory_ready = 1'b0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [15:0] words);
        start_address  = a;
        transfer_words = words;
        dma_request    = 1'b1;
    endtask

    task automatic drop_req();
        dma_request = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        peripheral_valid   = 1'b1;
        peripheral_data_in = b;
        acc = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            acc = peripheral_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        peripheral_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=not_accepted required=accepted byte=0x%0h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_events(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending actual=%0d required=0 events outstanding", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wc0;
        int pr0;
        int n;
        reset              = 1'b0;
        dma_request        = 1'b0;
        start_address      = '0;
        transfer_words     = '0;
        peripheral_valid   = 1'b0;
        peripheral_data_in = '0;
        memory_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {67'd0, dma_ack, busy, abort, peripheral_ready, memory_write_enable}, 72'd0);
        check("rst_addr", {40'd0, memory_address}, 72'd0);
        check("rst_data", {40'd0, memory_data_out}, 72'd0);
        reset = 1'b1;
        tick(2);

        // single word, little-endian packing
        exp_ack();
        exp_write(32'h0000_0010, 32'h1234_5678);
        exp_ack();
        start_req(32'h0000_0010, 16'd1);
        send_word(32'h1234_5678);
        wait_events("t1");
        tick(1);
        check("t1_busy_release", {71'd0, busy}, 72'd1);
        dma_request = 1'b0;
        tick(1);
        check("t1_busy_idle", {71'd0, busy}, 72'd0);
        tick(1);

        // three words across address wrap with a stalling memory
        mem_mode = 1;
        wc0 = write_count;
        exp_ack();
        exp_write(32'hFFFF_FFF8, 32'h0403_0201);
        exp_write(32'hFFFF_FFFC, 32'h0807_0605);
        exp_write(32'h0000_0000, 32'h0C0B_0A09);
        exp_ack();
        start_req(32'hFFFF_FFF8, 16'd3);
        send_word(32'h0403_0201);
        send_word(32'h0807_0605);
        send_word(32'h0C0B_0A09);
        wait_events("t2");
        check("t2_write_count", 72'(write_count - wc0), 72'd3);
        drop_req();
        mem_mode = 0;
        tick(1);

        // zero-length transfer
        pr0 = pready_cycles;
        exp_ack();
        exp_ack();
        start_req(32'h0000_0040, 16'd0);
        wait_events("t3");
        check("t3_ack_gap", 72'(ack_cyc_last - ack_cyc_prev), 72'd1);
        tick(2);
        check("t3_no_pready", 72'(pready_cycles - pr0), 72'd0);
        drop_req();

        // request dropped mid-word, then a clean follow-up word
        exp_ack();
        exp_abort();
        start_req(32'h0000_0080, 16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        dma_request = 1'b0;
        wait_events("t4_abort");
        tick(2);
        exp_ack();
        exp_write(32'h0000_0080, 32'h01EF_CDAB);
        exp_ack();
        start_req(32'h0000_0080, 16'd1);
        send_word(32'h01EF_CDAB);
        wait_events("t4_next");
        drop_req();

        // asynchronous reset while a write is pending
        mem_mode = 2;
        exp_ack();
        start_req(32'h0000_0200, 16'd1);
        send_word(32'hDEAD_BEEF);
        wait_events("t5_grant");
        n = 0;
        while (!memory_write_enable && n < 50) begin
            tick(1);
            n++;
        end
        check("t5_write_pending", {71'd0, memory_write_enable}, 72'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_ctrl", {67'd0, dma_ack, busy, abort, peripheral_ready, memory_write_enable}, 72'd0);
        check("t5_rst_addr", {40'd0, memory_address}, 72'd0);
        check("t5_rst_data", {40'd0, memory_data_out}, 72'd0);
        dma_request = 1'b0;
        mem_mode    = 0;
        tick(2);
        reset = 1'b1;
        tick(1);
        exp_ack();
        exp_write(32'h0000_0300, 32'hCAFE_F00D);
        exp_ack();
        start_req(32'h0000_0300, 16'd1);
        send_word(32'hCAFE_F00D);
        wait_events("t5_after");
        drop_req();

        // unaligned start address is forced to a word boundary
        exp_ack();
        exp_write(32'h0000_0010, 32'h4433_2211);
        exp_ack();
        start_req(32'h0000_0013, 16'd1);
        send_word(32'h4433_2211);
        wait_events("t6");
        drop_req();

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
